// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers: FSM state encoding and the
// packed payload layouts carried across each stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Single-entry stages call their occupied state FULL; it is the same encoding as ONE.
  localparam state_e FULL = ONE;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

  localparam int IFID_W = $bits(ifid_t);
  localparam int IDEX_W = $bits(idex_t);

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream side (in_*)
// and downstream side (out_*). The stage itself connects through the slave modport.
interface pipe_stage_hs_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_slot.sv
// One storage entry (valid + payload) with load and clear controls.
// Clear only drops the valid bit; the payload register keeps its contents.
module pipe_skid_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the payload register is reset as well, because out_data must read 0
    // out of reset even when the stage is built to hold stale payloads.
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      // NOTE: flop state is always written with <= so every flop samples pre-edge values.
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional skid entry and a saturating counter of downstream-starved cycles.
module pipe_stage_hs #(
  parameter int unsigned DATA_W      = 32,
  parameter bit          SKID        = 1'b0,
  parameter bit          ZERO_BUBBLE = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_hs_if.slave   bus,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  import pipe_pkg::*;

  state_e            state_q, state_d;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_d;
  logic              in_xfer, out_xfer;

  // Input offered during a flush is dropped even though in_ready is high.
  assign in_xfer  = bus.in_valid & bus.in_ready & ~flush;
  assign out_xfer = main_valid & bus.out_ready;
  assign main_d   = main_from_skid ? skid_data : bus.in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            // Only reachable with SKID=1; the single-entry in_ready blocks it otherwise.
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (out_xfer) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        TWO: if (out_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_d        = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  pipe_skid_slot #(.DATA_W(DATA_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_data)
  );

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;

      pipe_skid_slot #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (bus.in_data),
        .valid (skid_valid),
        .q     (skid_data)
      );

      // Registered ready: high exactly when the skid entry will be free next cycle.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) in_ready_q <= 1'b1;
        else       in_ready_q <= (state_d != TWO);
      end

      assign bus.in_ready = in_ready_q | flush;
    end else begin : g_single
      assign skid_valid   = 1'b0;
      assign skid_data    = '0;
      assign bus.in_ready = flush | ~main_valid | bus.out_ready;
    end
  endgenerate

  logic unused_ctl;
  assign unused_ctl = &{1'b0, skid_valid, skid_load, skid_clear};

  assign bus.out_valid = main_valid;
  assign bus.out_data  = (ZERO_BUBBLE && !main_valid) ? '0 : main_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (clr_cnt) begin
      bubble_cnt <= '0;
    end else if (bus.out_ready && !main_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three configurations driven with identical stimulus,
// each checked every cycle against a queue-based reference model.
module tb_pipe_stage_hs;
  import pipe_pkg::*;

  localparam int DW = IDEX_W;
  localparam int N  = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          iv    = 1'b0;
  logic          ordy  = 1'b0;
  logic          fl    = 1'b0;
  logic          clr   = 1'b0;
  logic [DW-1:0] idat  = '0;

  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [7:0]  cnt2;

  pipe_stage_hs_if #(.DATA_W(DW)) bus0 ();
  pipe_stage_hs_if #(.DATA_W(DW)) bus1 ();
  pipe_stage_hs_if #(.DATA_W(DW)) bus2 ();

  // dut0: single entry; dut1: skid, 4-bit counter; dut2: skid, payload held when idle.
  pipe_stage_hs #(.DATA_W(DW), .SKID(1'b0), .ZERO_BUBBLE(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .flush(fl), .clr_cnt(clr), .bubble_cnt(cnt0));
  pipe_stage_hs #(.DATA_W(DW), .SKID(1'b1), .ZERO_BUBBLE(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .flush(fl), .clr_cnt(clr), .bubble_cnt(cnt1));
  pipe_stage_hs #(.DATA_W(DW), .SKID(1'b1), .ZERO_BUBBLE(1'b0), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .flush(fl), .clr_cnt(clr), .bubble_cnt(cnt2));

  always #5 clk = ~clk;

  assign bus0.in_valid = iv;  assign bus0.in_data = idat;  assign bus0.out_ready = ordy;
  assign bus1.in_valid = iv;  assign bus1.in_data = idat;  assign bus1.out_ready = ordy;
  assign bus2.in_valid = iv;  assign bus2.in_data = idat;  assign bus2.out_ready = ordy;

  logic          ov[N];
  logic          ir[N];
  logic [DW-1:0] od[N];
  logic [31:0]   bc[N];
  assign ov[0] = bus0.out_valid;  assign ir[0] = bus0.in_ready;  assign od[0] = bus0.out_data;
  assign ov[1] = bus1.out_valid;  assign ir[1] = bus1.in_ready;  assign od[1] = bus1.out_data;
  assign ov[2] = bus2.out_valid;  assign ir[2] = bus2.in_ready;  assign od[2] = bus2.out_data;
  assign bc[0] = 32'(cnt0);
  assign bc[1] = 32'(cnt1);
  assign bc[2] = 32'(cnt2);

  // Reference model: each stage is a FIFO of capacity 1 or 2.
  logic [DW-1:0] mq[N][$];
  logic [DW-1:0] last[N];
  longint        mcnt[N];
  int            cap[N];
  bit            zb[N];
  longint        cmax[N];

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit         iv;
    logic [7:0] d;
    bit         ordy;
    bit         fl;
    bit         clr;
    bit         e_ov;
    logic [7:0] e_od;
    bit         e_ir;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_ir(int k);
    if (fl) return 1'b1;
    if (cap[k] == 1) return (mq[k].size() == 0) || ordy;
    return mq[k].size() < 2;
  endfunction

  function automatic logic [DW-1:0] exp_od(int k);
    if (mq[k].size() > 0) return mq[k][0];
    return zb[k] ? '0 : last[k];
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      last[k] = '0;
      mcnt[k] = 0;
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < N; k++) begin
      check($sformatf("dut%0d out_valid", k), DW'(ov[k]), DW'(mq[k].size() > 0));
      check($sformatf("dut%0d out_data", k), od[k], exp_od(k));
      check($sformatf("dut%0d in_ready", k), DW'(ir[k]), DW'(exp_ir(k)));
      check($sformatf("dut%0d bubble_cnt", k), DW'(bc[k]), DW'(mcnt[k]));
    end
  endtask

  task automatic update_model();
    for (int k = 0; k < N; k++) begin
      logic acc = iv && exp_ir(k);
      int   sz  = mq[k].size();
      if (clr) mcnt[k] = 0;
      else if (ordy && sz == 0 && mcnt[k] < cmax[k]) mcnt[k]++;
      if (fl) begin
        if (sz > 0) last[k] = mq[k][0];
        mq[k].delete();
      end else begin
        if (ordy && sz > 0) last[k] = mq[k].pop_front();
        if (acc) mq[k].push_back(idat);
      end
    end
  endtask

  // Inputs change at posedge+1; outputs are sampled at the following negedge.
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    to_neg();
    finish_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cap  = '{1, 2, 2};
    zb   = '{1'b1, 1'b1, 1'b0};
    cmax = '{65535, 15, 255};

    // Directed SKID=1 stream / backpressure / flush / clear; expectations are for dut1.
    //           iv  d      ordy fl clr  ov  od     ir  cnt
    tbl[0]  = '{1, 8'h11, 1, 0, 0,  0, 8'h00, 1, 4'd0};
    tbl[1]  = '{1, 8'h22, 1, 0, 0,  1, 8'h11, 1, 4'd1};
    tbl[2]  = '{1, 8'h33, 1, 0, 0,  1, 8'h22, 1, 4'd1};
    tbl[3]  = '{0, 8'h00, 1, 0, 0,  1, 8'h33, 1, 4'd1};
    tbl[4]  = '{0, 8'h00, 0, 0, 0,  0, 8'h00, 1, 4'd1};
    tbl[5]  = '{1, 8'h0A, 0, 0, 0,  0, 8'h00, 1, 4'd1};
    tbl[6]  = '{1, 8'h0B, 0, 0, 0,  1, 8'h0A, 1, 4'd1};
    tbl[7]  = '{1, 8'h0C, 0, 0, 0,  1, 8'h0A, 0, 4'd1};
    tbl[8]  = '{0, 8'h00, 1, 0, 0,  1, 8'h0A, 0, 4'd1};
    tbl[9]  = '{0, 8'h00, 1, 0, 0,  1, 8'h0B, 1, 4'd1};
    tbl[10] = '{0, 8'h00, 0, 0, 0,  0, 8'h00, 1, 4'd1};
    tbl[11] = '{1, 8'hA1, 0, 0, 0,  0, 8'h00, 1, 4'd1};
    tbl[12] = '{1, 8'hB2, 0, 0, 0,  1, 8'hA1, 1, 4'd1};
    tbl[13] = '{1, 8'h0C, 0, 1, 0,  1, 8'hA1, 1, 4'd1};
    tbl[14] = '{0, 8'h00, 0, 0, 0,  0, 8'h00, 1, 4'd1};
    tbl[15] = '{0, 8'h00, 1, 0, 0,  0, 8'h00, 1, 4'd1};
    tbl[16] = '{0, 8'h00, 1, 0, 1,  0, 8'h00, 1, 4'd2};
    tbl[17] = '{0, 8'h00, 0, 0, 0,  0, 8'h00, 1, 4'd0};

    reset_model();
    #12;
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset dut%0d out_valid", k), DW'(ov[k]), DW'(0));
      check($sformatf("reset dut%0d in_ready", k), DW'(ir[k]), DW'(1));
      check($sformatf("reset dut%0d out_data", k), od[k], DW'(0));
      check($sformatf("reset dut%0d bubble_cnt", k), DW'(bc[k]), DW'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      iv   = tbl[i].iv;
      idat = DW'(tbl[i].d);
      ordy = tbl[i].ordy;
      fl   = tbl[i].fl;
      clr  = tbl[i].clr;
      to_neg();
      check($sformatf("tbl%0d out_valid", i), DW'(ov[1]), DW'(tbl[i].e_ov));
      check($sformatf("tbl%0d out_data", i), od[1], DW'(tbl[i].e_od));
      check($sformatf("tbl%0d in_ready", i), DW'(ir[1]), DW'(tbl[i].e_ir));
      check($sformatf("tbl%0d bubble_cnt", i), DW'(bc[1]), DW'(tbl[i].e_cnt));
      finish_cycle();
    end

    // SKID=0 backpressure: FULL with 0xA holds while downstream stalls.
    iv = 1'b0; ordy = 1'b0; fl = 1'b1; clr = 1'b0;
    cycle();
    fl = 1'b0; iv = 1'b1; idat = DW'(8'h0A);
    cycle();
    idat = DW'(8'h05);
    for (int i = 0; i < 5; i++) begin
      to_neg();
      check("skid0 hold in_ready", DW'(ir[0]), DW'(0));
      check("skid0 hold out_valid", DW'(ov[0]), DW'(1));
      check("skid0 hold out_data", od[0], DW'(8'h0A));
      finish_cycle();
    end

    // Asynchronous reset between edges while dut1 sits in TWO.
    #2;
    reset = 1'b1;
    #1;
    check("async reset out_valid", DW'(ov[1]), DW'(0));
    check("async reset in_ready", DW'(ir[1]), DW'(1));
    check("async reset out_data", od[1], DW'(0));
    check("async reset dut2 out_data", od[2], DW'(0));
    reset_model();
    iv = 1'b0; ordy = 1'b0; fl = 1'b0; clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Counter saturation on the 4-bit counter, then clear beating an increment.
    ordy = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    to_neg();
    check("sat bubble_cnt", DW'(bc[1]), DW'(15));
    finish_cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    ordy = 1'b0;
    to_neg();
    check("clr bubble_cnt", DW'(bc[1]), DW'(0));
    finish_cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = (c % 64 < 16) ? 1'b1 : ($urandom_range(0, 9) < 5);
      fl   = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      idat = rnd();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush, and an optional skid entry. It sits between any two processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries an opaque packed payload. Downstream backpressure is a `ready` signal rather than a separate stall line. A saturating counter records cycles in which the downstream stage was starved.

## Interface
- `DATA_W`, 32: payload width in bits; legal range is 1 or more.
- `SKID`, 0: 0 gives a single entry with a combinational `in_ready`; 1 gives two entries with a registered `in_ready`.
- `ZERO_BUBBLE`, 1: 1 forces `out_data` to all-zero whenever `out_valid` is 0; 0 holds the last payload.
- `CNT_W`, 16: width of the bubble counter.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_valid` in 1: the upstream stage presents a payload.
- `in_ready` out 1: the stage can accept a payload this cycle.
- `in_data` in `DATA_W`: upstream payload (packed fields, e.g. RD1/RD2/PC/Rs1/Rs2/Rd/Imm/PC+4).
- `flush` in 1: synchronous kill of every held entry (branch mispredict or hazard clear).
- `out_valid` out 1: the stage holds a payload for downstream.
- `out_ready` in 1: downstream accepts the payload this cycle.
- `out_data` out `DATA_W`: head payload.
- `bubble_cnt` out `CNT_W`: saturating count of starved cycles.
- `clr_cnt` in 1: synchronous clear of `bubble_cnt`.

## Operation
- A transfer occurs on the input side when `in_valid && in_ready`, and on the output side when `out_valid && out_ready`.
- SKID=0 states are EMPTY and FULL:
  - `in_ready = !out_valid || out_ready`.
  - In EMPTY, an input transfer loads the payload and moves to FULL.
  - In FULL, an output transfer with a simultaneous input transfer reloads the entry and stays FULL.
  - In FULL, an output transfer alone moves to EMPTY.
  - In FULL with no output transfer, the payload holds.
- SKID=1 states are EMPTY, ONE and TWO, with a main entry and a skid entry:
  - `in_ready = !skid_valid`, and it is driven from a flop.
  - In ONE, an input transfer without an output transfer places the new payload in skid and moves to TWO.
  - In TWO, an output transfer promotes skid into main and moves to ONE.
  - In ONE, simultaneous input and output transfers load main and stay ONE.
  - Ordering is strictly FIFO.
- `flush` has priority over everything except `reset`:
  - Next state is EMPTY, and the payload is zeroed when ZERO_BUBBLE=1.
  - Any input presented in the flush cycle is dropped.
  - `in_ready` is forced to 1 during flush so upstream never deadlocks.
- Bubble counting:
  - `bubble_cnt` increments when `out_ready && !out_valid`, including the flush cycle if that condition holds.
  - It saturates at 2^CNT_W−1.
  - `clr_cnt` wins over an increment in the same cycle.
- No arithmetic is performed on the payload; it passes bit-exact.

## Timing
- Latency is 1 cycle: a payload accepted at edge N is visible on `out_data`/`out_valid` after edge N.
- Throughput is 1 transfer per cycle under continuous `out_ready` for both SKID values.
- SKID=1 adds no latency; the skid entry is used only under backpressure.
- Reset values while `reset` is high:
  - `out_valid` = 0, `in_ready` = 1.
  - `out_data` = 0, `bubble_cnt` = 0.
  - Internal state is EMPTY and the skid entry is invalid.
- Reset released mid-operation restarts from EMPTY; held payloads are lost by design.
- `flush` takes effect at the next edge: `out_valid` = 0 in the following cycle.
- A payload accepted in the cycle before flush is also killed.

## Structure
- The shared package `pipe_pkg` holds:
  - the state enum (EMPTY/ONE/TWO, with FULL aliasing ONE);
  - the packed payload typedefs per stage boundary (e.g. `idex_t`) and their widths.
- Instantiating code sets `DATA_W` to `$bits(idex_t)`.
- One sub-module is natural: `pipe_skid_slot`, a single entry holding valid + data with load/clear controls, instantiated once (SKID=0) or twice (SKID=1).
- The control FSM and counter live in the top module.

## Test plan
- Reset mid-stream: with SKID=1, hold in TWO and assert `reset` asynchronously between edges → `out_valid` = 0, `in_ready` = 1, `out_data` = 0 immediately.
- Streaming: with `out_ready` = 1 held, send 0x11, 0x22, 0x33 on consecutive cycles → the same sequence appears one cycle later with no bubbles, and `bubble_cnt` counts only the cycle before the first arrival.
- Backpressure with SKID=1:
  - Send 0xA then 0xB while `out_ready` = 0 → `in_ready` drops after 0xB.
  - Raise `out_ready` → 0xA, then 0xB, then `in_ready` = 1.
- Backpressure with SKID=0: under `out_ready` = 0 with FULL holding 0xA, `in_ready` = 0 and 0xA holds indefinitely.
- Flush in TWO with `in_valid` = 1 carrying 0xC → next cycle `out_valid` = 0, `out_data` = 0, 0xC never appears, `in_ready` = 1.
- Counter saturation: with CNT_W=4, hold `out_ready` = 1 and `in_valid` = 0 for 20 cycles → `bubble_cnt` = 15. Assert `clr_cnt` together with a starved cycle → 0.
